// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition RAM writer (acq) and its readback path (acq_reader).
package acq_pkg;

    localparam int DEF_RAM_DATA_W = 16;
    localparam int DEF_RAM_ADDR_W = 19;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush and occupancy count.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/acq_reader.sv
// Streams a programmed range of acquisition-RAM words to the host link as bytes, LSB first.
module acq_reader import acq_pkg::*; #(
    parameter int RAM_DATA_W = DEF_RAM_DATA_W,
    parameter int RAM_ADDR_W = DEF_RAM_ADDR_W,
    parameter int RAM_RD_LAT = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    input  logic                  rd_abort,
    input  logic [RAM_ADDR_W-1:0] rd_addr,
    input  logic [RAM_ADDR_W:0]   rd_words,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [RAM_ADDR_W-1:0] ram_raddr,
    output logic                  ram_ren,
    input  logic [RAM_DATA_W-1:0] ram_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int BYTES = RAM_DATA_W / 8;
    localparam int IFL_W = $clog2(RAM_RD_LAT + 1) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ((IFL_W > CNT_W) ? IFL_W : CNT_W) + 1;
    localparam int BL_W  = $clog2(BYTES) + 1;

    rd_state_e             state_q, state_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic [RAM_ADDR_W:0]   remaining_q, remaining_d;
    logic [IFL_W-1:0]      in_flight_q, in_flight_d;
    logic [RAM_RD_LAT-1:0] pipe_q, pipe_d;
    logic                  done_q, done_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [RAM_DATA_W-1:0] hold_q, hold_d;
    logic [BL_W-1:0]       bytes_left_q, bytes_left_d;

    logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [RAM_DATA_W-1:0] fifo_rdata, word;
    logic [CNT_W-1:0]      fifo_count;
    logic                  abort, credit_ok, ren, pipe_out;
    logic                  accept, shift, need_word, load, bypass, last_accepted;

    sync_fifo #(.DATA_W(RAM_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (fifo_push),
        .push_data (ram_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Credit: every outstanding read must already own a FIFO slot when it lands.
    assign abort     = rd_abort && (state_q != RD_IDLE);
    assign credit_ok = (SUM_W'(in_flight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign ren       = (state_q == RD_RUN) && (remaining_q != '0) && credit_ok && !abort;
    assign pipe_out  = pipe_q[RAM_RD_LAT-1];

    // An idle serializer takes a landing word straight off the RAM bus, saving the FIFO cycle.
    assign accept        = tx_valid_q && tx_ready;
    assign last_accepted = accept && (bytes_left_q == '0);
    assign shift         = accept && (bytes_left_q != '0);
    assign need_word     = !tx_valid_q || last_accepted;
    assign load          = need_word && (!fifo_empty || pipe_out) && !abort;
    assign bypass        = load && fifo_empty;
    assign fifo_pop      = load && !fifo_empty;
    assign fifo_push     = pipe_out && !bypass && !abort;
    assign word          = fifo_empty ? ram_rdata : fifo_rdata;

    always_comb begin
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        hold_d       = hold_q;
        bytes_left_d = bytes_left_q;
        if (abort) begin
            tx_valid_d   = 1'b0;
            bytes_left_d = '0;
        end else if (shift) begin
            tx_data_d    = hold_q[7:0];
            hold_d       = hold_q >> 8;
            bytes_left_d = bytes_left_q - 1'b1;
        end else if (load) begin
            tx_data_d    = word[7:0];
            hold_d       = word >> 8;
            bytes_left_d = BL_W'(BYTES - 1);
            tx_valid_d   = 1'b1;
        end else if (need_word) begin
            tx_valid_d   = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        pipe_d      = abort ? '0 : ((pipe_q << 1) | RAM_RD_LAT'(ren));
        in_flight_d = abort ? '0 : (in_flight_q + IFL_W'(ren) - IFL_W'(pipe_out));
        case (state_q)
            RD_IDLE: begin
                if (rd_start && !rd_abort) begin
                    if (rd_words != '0) begin
                        state_d     = RD_RUN;
                        addr_d      = rd_addr;
                        remaining_d = rd_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_RUN: begin
                if (abort) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = RD_DRAIN;
                end else if (ren) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            RD_DRAIN: begin
                if (abort || ((in_flight_q == '0) && fifo_empty && (!tx_valid_q || last_accepted))) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            in_flight_q  <= '0;
            pipe_q       <= '0;
            done_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            bytes_left_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            in_flight_q  <= in_flight_d;
            pipe_q       <= pipe_d;
            done_q       <= done_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            bytes_left_q <= bytes_left_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

    assign rd_busy   = (state_q != RD_IDLE);
    assign rd_done   = done_q;
    assign ram_raddr = addr_q;
    assign ram_ren   = ren;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_acq_reader.sv
// Scoreboard bench for acq_reader: RAM model, expected-byte queue, decoupled output monitor.
module tb_acq_reader;

    localparam int DW    = 16;
    localparam int AW    = 19;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_start = 1'b0;
    logic          rd_abort = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW:0]   rd_words = '0;
    logic          tx_ready = 1'b0;
    logic          rd_busy, rd_done, ram_ren, tx_valid;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [7:0]    tx_data;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int ren_cnt = 0;
    int byte_cnt = 0;
    int txv_cnt = 0;
    int ready_pct = 100;
    logic [7:0]    exp_q[$];
    logic [AW-1:0] raddr_log[$];
    logic [DW-1:0] ram_pipe [LAT];

    always #5 clk = ~clk;

    acq_reader #(.RAM_DATA_W(DW), .RAM_ADDR_W(AW), .RAM_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_start  (rd_start),
        .rd_abort  (rd_abort),
        .rd_addr   (rd_addr),
        .rd_words  (rd_words),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .ram_raddr (ram_raddr),
        .ram_ren   (ram_ren),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return 16'hA000 + {4'h0, a[11:0]};
    endfunction

    // RAM: data for a read appears LAT cycles after ram_ren.
    always @(posedge clk) begin
        ram_pipe[0] <= ram_ren ? ram_word(ram_raddr) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_rdata = ram_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_done) done_cnt++;
                if (ram_ren) begin
                    ren_cnt++;
                    raddr_log.push_back(ram_raddr);
                end
                if (tx_valid) txv_cnt++;
                if (tx_valid && tx_ready) begin
                    byte_cnt++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h with no byte expected", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            fails++;
                            $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        rd_abort = 1'b0;
        tx_ready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [AW:0] w);
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        tick();
        rd_addr  = a;
        rd_words = w;
        rd_start = 1'b1;
        for (int i = 0; i < int'(w); i++) begin
            wa = AW'(a + i);
            wd = ram_word(wa);
            exp_q.push_back(wd[7:0]);
            exp_q.push_back(wd[15:8]);
        end
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        check(name, done_cnt != base, 1);
    endtask

    initial begin
        int d0, r0, v0, b0, n, run, w;
        logic [AW-1:0] a;
        repeat (3) tick();
        check("reset_outputs", {rd_busy, rd_done, ram_ren, tx_valid, tx_data, ram_raddr}, '0);
        rst = 1'b0;
        tick();

        ready_pct = 100;
        d0 = done_cnt;
        start(19'h10, 20'd4);
        n = 0;
        do begin tick(); n++; end while (!tx_valid && n < 20);
        check("t1_first_byte_latency", n, LAT + 2);
        run = 1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (!tx_valid) break;
            run++;
        end
        check("t1_contiguous_bytes", run, 8);
        repeat (3) tick();
        check("t1_one_done", done_cnt - d0, 1);
        check("t1_busy_low", rd_busy, 0);
        check("t1_all_bytes", exp_q.size(), 0);

        ready_pct = 30;
        d0 = done_cnt;
        r0 = ren_cnt;
        start(19'h10, 20'd4);
        wait_done("t2_done", d0, 400);
        check("t2_ren_count", ren_cnt - r0, 4);
        check("t2_all_bytes", exp_q.size(), 0);

        ready_pct = 100;
        raddr_log.delete();
        d0 = done_cnt;
        start(19'h7FFFE, 20'd4);
        wait_done("t3_done", d0, 200);
        check("t3_raddr_count", raddr_log.size(), 4);
        for (int i = 0; i < 4 && i < raddr_log.size(); i++)
            check($sformatf("t3_raddr_%0d", i), raddr_log[i], AW'(19'h7FFFE + i));

        d0 = done_cnt;
        r0 = ren_cnt;
        v0 = txv_cnt;
        start(19'h55, 20'd0);
        tick();
        check("t4_done_next_cycle", rd_done, 1);
        check("t4_busy_low", rd_busy, 0);
        repeat (5) tick();
        check("t4_no_ren", ren_cnt - r0, 0);
        check("t4_no_tx_valid", txv_cnt - v0, 0);
        check("t4_one_done", done_cnt - d0, 1);

        ready_pct = 100;
        start(19'h0, 20'd1000);
        b0 = byte_cnt;
        n = 0;
        while (byte_cnt - b0 < 37 && n < 500) begin
            tick();
            n++;
        end
        check("t5_bytes_before_abort", byte_cnt - b0, 37);
        tick();
        rd_abort = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        #1;
        check("t5_ren_low_on_abort", ram_ren, 0);
        tick();
        check("t5_tx_valid_low", tx_valid, 0);
        check("t5_done_pulse", rd_done, 1);
        check("t5_busy_low", rd_busy, 0);
        repeat (5) tick();
        check("t5_one_done", done_cnt - d0, 1);
        d0 = done_cnt;
        start(19'h0, 20'd2);
        wait_done("t5_next_done", d0, 200);
        check("t5_next_all_bytes", exp_q.size(), 0);

        ready_pct = 30;
        d0 = done_cnt;
        r0 = ren_cnt;
        start(19'h20, 20'd6);
        tick();
        repeat (3) begin
            tick();
            rd_addr  = 19'h300;
            rd_words = 20'd5;
            rd_start = 1'b1;
        end
        wait_done("t6_done", d0, 800);
        check("t6_ren_count", ren_cnt - r0, 6);
        check("t6_one_done", done_cnt - d0, 1);
        check("t6_all_bytes", exp_q.size(), 0);

        ready_pct = 100;
        start(19'h40, 20'd50);
        repeat (10) tick();
        tick();
        rst = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        tick();
        rst = 1'b0;
        check("t6_outputs_after_rst", {rd_busy, rd_done, ram_ren, tx_valid, tx_data, ram_raddr}, '0);
        repeat (20) tick();
        check("t6_no_spurious_done", done_cnt - d0, 0);
        check("t6_idle_after_rst", {rd_busy, tx_valid}, 0);
        d0 = done_cnt;
        start(19'h5, 20'd3);
        wait_done("t6_post_rst_done", d0, 200);
        check("t6_post_rst_bytes", exp_q.size(), 0);

        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom());
            if (k % 2 == 1) a = AW'(19'h7FFF0 + $urandom_range(15));
            w = $urandom_range(24, 1);
            case (k % 3)
                0:       ready_pct = 30;
                1:       ready_pct = 70;
                default: ready_pct = 100;
            endcase
            d0 = done_cnt;
            r0 = ren_cnt;
            start(a, AW'(w) + 20'd0);
            wait_done($sformatf("rand%0d_done", k), d0, 2000);
            check($sformatf("rand%0d_ren", k), ren_cnt - r0, w);
            check($sformatf("rand%0d_bytes", k), exp_q.size(), 0);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the end, %0d failed so far", fails);
        $fatal(1);
    end

endmodule
